// File: rtl/vit_pkg.sv
// Shared ViT front-end geometry: pixel type, image/patch sizes and derived index widths.
// Used by the patchifier and by the patch streamer.
package vit_pkg;

  localparam int CHANNEL_SIZE      = 8;
  localparam int NUM_CHANNELS      = 3;
  localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int IMG_WIDTH         = 16;
  localparam int IMG_HEIGHT        = 16;
  localparam int PATCH_SIZE        = 4;
  localparam int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
  localparam int PATCHES_IN_COL    = IMG_HEIGHT / PATCH_SIZE;
  localparam int TOTAL_NUM_PATCHES = PATCHES_IN_ROW * PATCHES_IN_COL;
  localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;

  // Pixel coordinates split into {patch column/row, offset inside the patch}.
  localparam int X_W    = $clog2(IMG_WIDTH);
  localparam int Y_W    = $clog2(IMG_HEIGHT);
  localparam int OFF_W  = $clog2(PATCH_SIZE);
  localparam int PC_W   = X_W - OFF_W;
  localparam int PR_W   = Y_W - OFF_W;
  localparam int PIDX_W = $clog2(TOTAL_NUM_PATCHES);

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef logic [PIDX_W-1:0]      pidx_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_t;

  typedef struct packed {
    pixel_t data;
    pidx_t  idx;
    logic   sop;
    logic   eop;
    logic   last;
  } beat_t;

endpackage

// File: rtl/patch_addr_gen.sv
// Walks a frame in patch-major order and produces the pixel coordinate plus
// sop/eop/last markers of the beat it currently points at.
module patch_addr_gen
  import vit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           adv_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output pidx_t          p_o,
  output logic           sop_o,
  output logic           eop_o,
  output logic           last_o
);

  // Separate column/row counters keep x/y as plain concatenations, no divide.
  logic [OFF_W-1:0] c_q, c_d;
  logic [OFF_W-1:0] r_q, r_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PR_W-1:0]  pr_q, pr_d;
  pidx_t            p_q, p_d;

  logic c_end, r_end, pc_end, pr_end;

  assign c_end  = (c_q == OFF_W'(PATCH_SIZE - 1));
  assign r_end  = (r_q == OFF_W'(PATCH_SIZE - 1));
  assign pc_end = (pc_q == PC_W'(PATCHES_IN_ROW - 1));
  assign pr_end = (pr_q == PR_W'(PATCHES_IN_COL - 1));

  assign x_o    = {pc_q, c_q};
  assign y_o    = {pr_q, r_q};
  assign p_o    = p_q;
  assign sop_o  = (c_q == '0) && (r_q == '0);
  assign eop_o  = c_end && r_end;
  assign last_o = eop_o && (p_q == PIDX_W'(TOTAL_NUM_PATCHES - 1));

  always_comb begin
    c_d  = c_q;
    r_d  = r_q;
    pc_d = pc_q;
    pr_d = pr_q;
    p_d  = p_q;
    if (adv_i) begin
      c_d = c_end ? '0 : c_q + 1'b1;
      if (c_end) begin
        r_d = r_end ? '0 : r_q + 1'b1;
        if (r_end) begin
          pc_d = pc_end ? '0 : pc_q + 1'b1;
          p_d  = last_o ? '0 : p_q + 1'b1;
          if (pc_end) begin
            pr_d = pr_end ? '0 : pr_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q  <= '0;
      r_q  <= '0;
      pc_q <= '0;
      pr_q <= '0;
      p_q  <= '0;
    end else begin
      c_q  <= c_d;
      r_q  <= r_d;
      pc_q <= pc_d;
      pr_q <= pr_d;
      p_q  <= p_d;
    end
  end

endmodule

// File: rtl/patch_streamer.sv
// Captures a whole frame in one cycle, then streams it patch-major, one pixel per beat.
// tok_* is a valid/ready channel: a beat moves when tok_valid && tok_ready on a rising edge;
// tok_valid never drops and tok_data/flags never change until that beat is accepted.
module patch_streamer
  import vit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   frame_valid,
  input  pixel_t frame [IMG_WIDTH][IMG_HEIGHT],
  output logic   frame_taken,
  output logic   tok_valid,
  input  logic   tok_ready,
  output pixel_t tok_data,
  output pidx_t  tok_patch_idx,
  output logic   tok_sop,
  output logic   tok_eop,
  output logic   tok_last,
  output logic   busy,
  output logic   done
);

  stream_state_t state_q;
  pixel_t        frame_buf_q [IMG_WIDTH][IMG_HEIGHT];
  beat_t         beat_q, beat_d;
  logic          tok_valid_q;
  logic          frame_taken_q;
  logic          done_q;
  logic          issued_all_q;

  logic [X_W-1:0] gen_x;
  logic [Y_W-1:0] gen_y;
  pidx_t          gen_p;
  logic           gen_sop, gen_eop, gen_last;
  logic           load_en;
  logic           accept;

  // The generator always points at the next beat to be loaded into the output register.
  assign load_en = (state_q == ST_STREAM) && !issued_all_q && (!tok_valid_q || tok_ready);
  assign accept  = tok_valid_q && tok_ready;

  patch_addr_gen u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .adv_i (load_en),
    .x_o   (gen_x),
    .y_o   (gen_y),
    .p_o   (gen_p),
    .sop_o (gen_sop),
    .eop_o (gen_eop),
    .last_o(gen_last)
  );

  always_comb begin
    beat_d      = '0;
    beat_d.data = frame_buf_q[gen_x][gen_y];
    beat_d.idx  = gen_p;
    beat_d.sop  = gen_sop;
    beat_d.eop  = gen_eop;
    beat_d.last = gen_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      tok_valid_q   <= 1'b0;
      frame_taken_q <= 1'b0;
      done_q        <= 1'b0;
      issued_all_q  <= 1'b0;
    end else begin
      frame_taken_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_valid) begin
            frame_buf_q   <= frame;
            frame_taken_q <= 1'b1;
            state_q       <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (load_en) begin
            beat_q      <= beat_d;
            tok_valid_q <= 1'b1;
            if (gen_last) begin
              issued_all_q <= 1'b1;
            end
          end else if (accept) begin
            beat_q      <= '0;
            tok_valid_q <= 1'b0;
          end
          // Only reachable once every beat is issued, so load_en is low here.
          if (accept && beat_q.last) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b1;
            issued_all_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frame_taken   = frame_taken_q;
  assign tok_valid     = tok_valid_q;
  assign tok_data      = beat_q.data;
  assign tok_patch_idx = beat_q.idx;
  assign tok_sop       = beat_q.sop;
  assign tok_eop       = beat_q.eop;
  assign tok_last      = beat_q.last;
  assign busy          = (state_q == ST_STREAM);
  assign done          = done_q;

endmodule

// File: tb/tb_patch_streamer.sv
// Scoreboard bench for patch_streamer: frames are modelled in the bench, expected beats
// are queued at drive time and popped as the DUT hands beats over.
module tb_patch_streamer;
  import vit_pkg::*;

  localparam int BEATS = TOTAL_NUM_PATCHES * PATCH_VECTOR_SIZE;
  localparam int BW    = PIXEL_WIDTH + PIDX_W + 3;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   frame_valid = 1'b0;
  pixel_t frame_tb [IMG_WIDTH][IMG_HEIGHT];
  logic   frame_taken;
  logic   tok_valid;
  logic   tok_ready = 1'b0;
  pixel_t tok_data;
  pidx_t  tok_patch_idx;
  logic   tok_sop, tok_eop, tok_last, busy, done;

  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] obs;
  logic [BW-1:0] e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign obs = {tok_data, tok_patch_idx, tok_sop, tok_eop, tok_last};

  patch_streamer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_valid  (frame_valid),
    .frame        (frame_tb),
    .frame_taken  (frame_taken),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_data     (tok_data),
    .tok_patch_idx(tok_patch_idx),
    .tok_sop      (tok_sop),
    .tok_eop      (tok_eop),
    .tok_last     (tok_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  // variant 0: {x, y, x+y}; otherwise random. push=0 changes the input without expectations.
  task automatic load_frame(input int variant, input bit push);
    int x, y;
    for (int i = 0; i < IMG_WIDTH; i++)
      for (int j = 0; j < IMG_HEIGHT; j++)
        frame_tb[i][j] = (variant == 0) ? {8'(i), 8'(j), 8'(i + j)} : pixel_t'($urandom);
    if (push) begin
      for (int p = 0; p < TOTAL_NUM_PATCHES; p++)
        for (int k = 0; k < PATCH_VECTOR_SIZE; k++) begin
          x = (p % PATCHES_IN_ROW) * PATCH_SIZE + (k % PATCH_SIZE);
          y = (p / PATCHES_IN_ROW) * PATCH_SIZE + (k / PATCH_SIZE);
          exp_q.push_back({frame_tb[x][y], PIDX_W'(p), k == 0, k == PATCH_VECTOR_SIZE - 1,
                           (k == PATCH_VECTOR_SIZE - 1) && (p == TOTAL_NUM_PATCHES - 1)});
        end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    frame_valid = 1'b0;
    tok_ready = 1'b0;
    load_frame(0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_taken, tok_valid, tok_data, tok_patch_idx, tok_sop, tok_eop, tok_last, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0",
               {frame_taken, tok_valid, tok_data, tok_patch_idx, tok_sop, tok_eop, tok_last, done});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, tok_valid, frame_taken} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b exp 000", {busy, tok_valid, frame_taken});
    end
  endtask

  task automatic test_stream_ready;
    int n, taken_cyc, lasts;
    n = 0; lasts = 0;
    load_frame(0, 1'b1);
    tok_ready = 1'b1;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    taken_cyc = cyc;
    checks++;
    if ({frame_taken, tok_valid, busy} !== 3'b101) begin
      errors++; $display("FAIL taken_latency got %b exp 101", {frame_taken, tok_valid, busy});
    end
    for (int t = 0; t < BEATS + 20 && n < BEATS; t++) begin
      @(negedge clk);
      if (t == 0) begin
        checks++;
        if ({tok_valid, frame_taken, tok_sop, tok_patch_idx, tok_data} !== {3'b101, PIDX_W'(0), 24'h000000}) begin
          errors++; $display("FAIL first_beat got v=%b ft=%b sop=%b idx=%0d d=%h", tok_valid,
                             frame_taken, tok_sop, tok_patch_idx, tok_data);
        end
      end
      if (done) begin errors++; checks++; $display("FAIL early_done at beat %0d", n); end
      if (tok_valid && tok_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_ready beat %0d got %h exp %h", n, obs, e); end
        if (n == 5) begin
          checks++;
          if (tok_data !== 24'h010102) begin errors++; $display("FAIL beat5 got %h exp 010102", tok_data); end
        end
        if (n == 16) begin
          checks++;
          if ({tok_data, tok_sop, tok_patch_idx} !== {24'h040004, 1'b1, PIDX_W'(1)}) begin
            errors++; $display("FAIL beat16 got %h sop=%b idx=%0d exp 040004 1 1", tok_data, tok_sop, tok_patch_idx);
          end
        end
        if (n == BEATS - 1) begin
          checks++;
          if ({tok_data, tok_last} !== {24'h0f0f1e, 1'b1}) begin
            errors++; $display("FAIL beat255 got %h last=%b exp 0f0f1e 1", tok_data, tok_last);
          end
        end
        if (tok_last) lasts++;
        n++;
      end
    end
    checks++;
    if (n != BEATS || lasts != 1) begin
      errors++; $display("FAIL beat_count got %0d lasts %0d exp %0d 1", n, lasts, BEATS);
    end
    @(negedge clk);
    checks++;
    if ({done, tok_valid} !== 2'b10) begin errors++; $display("FAIL done_pulse got %b exp 10", {done, tok_valid}); end
    checks++;
    if (cyc - taken_cyc != BEATS + 1) begin
      errors++; $display("FAIL throughput got %0d exp %0d", cyc - taken_cyc, BEATS + 1);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_one_cycle got %b exp 00", {done, busy}); end
  endtask

  task automatic test_random_stall;
    int n;
    bit stalled;
    logic [BW-1:0] held;
    n = 0; stalled = 1'b0; held = '0;
    load_frame(0, 1'b1);
    tok_ready = 1'b0;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    checks++;
    if (frame_taken !== 1'b1) begin errors++; $display("FAIL stall_taken got %b exp 1", frame_taken); end
    for (int t = 0; t < 5000 && n < BEATS; t++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if ({tok_valid, obs} !== {1'b1, held}) begin
          errors++; $display("FAIL stall_hold got v=%b %h exp 1 %h", tok_valid, obs, held);
        end
      end
      if (frame_taken) begin errors++; checks++; $display("FAIL stall_extra_taken at beat %0d", n); end
      tok_ready = ($urandom_range(0, 99) < 30);
      if (tok_valid && tok_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_stall beat %0d got %h exp %h", n, obs, e); end
        n++;
      end
      stalled = tok_valid && !tok_ready;
      held = obs;
    end
    checks++;
    if (n != BEATS) begin errors++; $display("FAIL stall_count got %0d exp %0d", n, BEATS); end
    @(negedge clk);
    checks++;
    if ({done, tok_valid} !== 2'b10) begin errors++; $display("FAIL stall_done got %b exp 10", {done, tok_valid}); end
    tok_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n, taken_cnt, done_cnt, done_cyc;
    n = 0; taken_cnt = 0; done_cnt = 0; done_cyc = -10;
    load_frame(1, 1'b1);
    tok_ready = 1'b1;
    frame_valid = 1'b1;
    for (int t = 0; t < 1200 && done_cnt < 2; t++) begin
      @(negedge clk);
      if (frame_taken) begin
        taken_cnt++;
        if (taken_cnt == 1) load_frame(1, 1'b1);
        if (taken_cnt == 2) begin
          checks++;
          if (cyc != done_cyc + 1) begin
            errors++; $display("FAIL b2b_capture_cycle got %0d exp %0d", cyc, done_cyc + 1);
          end
          frame_valid = 1'b0;
          load_frame(1, 1'b0);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (tok_valid && tok_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_b2b beat %0d got %h exp %h", n, obs, e); end
        n++;
      end
    end
    checks++;
    if (taken_cnt != 2 || done_cnt != 2 || n != 2 * BEATS) begin
      errors++; $display("FAIL b2b_counts got taken %0d done %0d beats %0d exp 2 2 %0d",
                         taken_cnt, done_cnt, n, 2 * BEATS);
    end
    @(negedge clk);
    checks++;
    if ({frame_taken, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b exp 00", {frame_taken, busy}); end
  endtask

  task automatic test_reset_mid;
    int n;
    bit saw_done;
    n = 0; saw_done = 1'b0;
    load_frame(0, 1'b1);
    tok_ready = 1'b1;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int t = 0; t < 300 && n < 100; t++) begin
      @(negedge clk);
      if (tok_valid && tok_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_prereset beat %0d got %h exp %h", n, obs, e); end
        n++;
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tok_valid, busy, frame_taken, done, tok_sop, tok_last} !== 6'b0) begin
      errors++; $display("FAIL mid_reset got %b exp 000000", {tok_valid, busy, frame_taken, done, tok_sop, tok_last});
    end
    reset = 1'b0;
    exp_q.delete();
    repeat (5) begin
      @(negedge clk);
      if (done || tok_valid) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL post_reset_activity got 1 exp 0"); end
    n = 0;
    load_frame(1, 1'b1);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int t = 0; t < BEATS + 20 && n < BEATS; t++) begin
      @(negedge clk);
      if (tok_valid && tok_ready) begin
        if (n == 0) begin
          checks++;
          if ({tok_sop, tok_patch_idx} !== {1'b1, PIDX_W'(0)}) begin
            errors++; $display("FAIL restart_first got sop=%b idx=%0d exp 1 0", tok_sop, tok_patch_idx);
          end
        end
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_restart beat %0d got %h exp %h", n, obs, e); end
        n++;
      end
    end
    @(negedge clk);
    checks++;
    if ({n == BEATS, done} !== 2'b11) begin errors++; $display("FAIL restart_done got beats %0d done %b", n, done); end
  endtask

  task automatic test_toggle_ready;
    int n, sops, eops;
    n = 0; sops = 0; eops = 0;
    load_frame(1, 1'b1);
    tok_ready = 1'b0;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    for (int t = 0; t < 3 * BEATS && n < BEATS; t++) begin
      @(negedge clk);
      tok_ready = ~tok_ready;
      if (tok_valid && tok_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sb_toggle beat %0d got %h exp %h", n, obs, e); end
        checks++;
        if (tok_patch_idx !== PIDX_W'(n / PATCH_VECTOR_SIZE)) begin
          errors++; $display("FAIL toggle_idx beat %0d got %0d exp %0d", n, tok_patch_idx, n / PATCH_VECTOR_SIZE);
        end
        if (tok_sop) sops++;
        if (tok_eop) eops++;
        n++;
      end
    end
    checks++;
    if (sops != TOTAL_NUM_PATCHES || eops != TOTAL_NUM_PATCHES || n != BEATS) begin
      errors++; $display("FAIL toggle_markers got sop %0d eop %0d beats %0d exp %0d %0d %0d",
                         sops, eops, n, TOTAL_NUM_PATCHES, TOTAL_NUM_PATCHES, BEATS);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL toggle_done got %b exp 1", done); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream_ready();
    test_random_stall();
    test_back_to_back();
    test_reset_mid();
    test_toggle_ready();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
